// File: rtl/gpr_wb_merge.sv
// GPR write-back merge: two in-order lanes pass straight through to the write ports,
// long-latency results queue in a small FIFO and drain into the port slots the lanes leave free.
module gpr_wb_merge #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lane0_we_i,
    input  logic [4:0]    lane0_num_i,
    input  logic [31:0]   lane0_data_i,
    input  logic          lane1_we_i,
    input  logic [4:0]    lane1_num_i,
    input  logic [31:0]   lane1_data_i,
    input  logic          ll_valid_i,
    output logic          ll_ready_o,
    input  logic [4:0]    ll_num_i,
    input  logic [31:0]   ll_data_i,
    output logic          wr0_en_o,
    output logic [4:0]    wr0_num_o,
    output logic [31:0]   wr0_data_o,
    output logic          wr1_en_o,
    output logic [4:0]    wr1_num_o,
    output logic [31:0]   wr1_data_o,
    output logic [31:0]   pend_mask_o,
    output logic [AW:0]   fifo_cnt_o
);

    logic [4:0]    num_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [AW:0]   count;
    logic          l0_act;
    logic          l1_act;
    logic          has1;
    logic          has2;
    logic          push;
    logic [1:0]    pop;

    // Writes to r0 are dropped at the door; an r0 long-latency beat still handshakes.
    always_comb begin
        l0_act     = rst && lane0_we_i && (lane0_num_i != '0);
        l1_act     = rst && lane1_we_i && (lane1_num_i != '0);
        has1       = rst && (count != '0);
        has2       = rst && (count > (AW+1)'(1));
        rd_ptr1    = rd_ptr + AW'(1);
        ll_ready_o = rst && (count < (AW+1)'(DEPTH));
        push       = ll_valid_i && ll_ready_o && (ll_num_i != '0);
        fifo_cnt_o = count;
    end

    // FIFO entries fill whichever ports the lanes leave idle, oldest entry on the lower port.
    always_comb begin
        wr0_en_o   = 1'b0;
        wr0_num_o  = '0;
        wr0_data_o = '0;
        wr1_en_o   = 1'b0;
        wr1_num_o  = '0;
        wr1_data_o = '0;
        pop        = 2'd0;
        if (l0_act) begin
            wr0_en_o   = 1'b1;
            wr0_num_o  = lane0_num_i;
            wr0_data_o = lane0_data_i;
        end else if (has1) begin
            wr0_en_o   = 1'b1;
            wr0_num_o  = num_q[rd_ptr];
            wr0_data_o = data_q[rd_ptr];
            pop        = 2'd1;
        end
        if (l1_act) begin
            wr1_en_o   = 1'b1;
            wr1_num_o  = lane1_num_i;
            wr1_data_o = lane1_data_i;
        end else if (l0_act) begin
            if (has1) begin
                wr1_en_o   = 1'b1;
                wr1_num_o  = num_q[rd_ptr];
                wr1_data_o = data_q[rd_ptr];
                pop        = 2'd1;
            end
        end else if (has2) begin
            wr1_en_o   = 1'b1;
            wr1_num_o  = num_q[rd_ptr1];
            wr1_data_o = data_q[rd_ptr1];
            pop        = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            rd_ptr <= rd_ptr + AW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num_q[wr_ptr]  <= ll_num_i;
            data_q[wr_ptr] <= ll_data_i;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count) begin
                pend_mask_o[num_q[rd_ptr + AW'(i)]] = 1'b1;
            end
        end
        pend_mask_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_gpr_wb_merge.sv
// Bench for gpr_wb_merge: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_gpr_wb_merge;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          lane0_we, lane1_we, ll_valid;
    logic [4:0]    lane0_num, lane1_num, ll_num;
    logic [31:0]   lane0_data, lane1_data, ll_data;
    logic          ll_ready;
    logic          wr0_en, wr1_en;
    logic [4:0]    wr0_num, wr1_num;
    logic [31:0]   wr0_data, wr1_data;
    logic [31:0]   pend_mask;
    logic [AW:0]   fifo_cnt;

    gpr_wb_merge #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .lane0_we_i(lane0_we), .lane0_num_i(lane0_num), .lane0_data_i(lane0_data),
        .lane1_we_i(lane1_we), .lane1_num_i(lane1_num), .lane1_data_i(lane1_data),
        .ll_valid_i(ll_valid), .ll_ready_o(ll_ready), .ll_num_i(ll_num), .ll_data_i(ll_data),
        .wr0_en_o(wr0_en), .wr0_num_o(wr0_num), .wr0_data_o(wr0_data),
        .wr1_en_o(wr1_en), .wr1_num_o(wr1_num), .wr1_data_o(wr1_data),
        .pend_mask_o(pend_mask), .fifo_cnt_o(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  num;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   m_pop;
    bit   m_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit w0, input logic [4:0] n0, input logic [31:0] d0,
                         input bit w1, input logic [4:0] n1, input logic [31:0] d1,
                         input bit v, input logic [4:0] ln, input logic [31:0] ld);
        lane0_we = w0; lane0_num = n0; lane0_data = d0;
        lane1_we = w1; lane1_num = n1; lane1_data = d1;
        ll_valid = v;  ll_num = ln;    ll_data = ld;
        @(negedge clk);
        model_check();
    endtask

    // Reference: lanes own their port; queued results fill the free ports in port order.
    task automatic model_check();
        bit          l0, l1;
        bit          e0, e1;
        ent_t        p0, p1;
        logic [31:0] mask;
        int          k;
        l0 = rst && lane0_we && (lane0_num != 0);
        l1 = rst && lane1_we && (lane1_num != 0);
        k = 0; e0 = 0; e1 = 0;
        p0 = '{num: lane0_num, data: lane0_data};
        p1 = '{num: lane1_num, data: lane1_data};
        if (!l0 && rst && k < q.size()) begin p0 = q[k]; k++; end
        e0 = l0 || (k == 1);
        if (!l1 && rst && k < q.size()) begin p1 = q[k]; k++; e1 = 1; end
        e1 = e1 || l1;
        mask = 0;
        foreach (q[i]) mask[q[i].num] = 1'b1;
        chk("wr0_en", 32'(wr0_en), 32'(e0));
        chk("wr1_en", 32'(wr1_en), 32'(e1));
        if (e0) begin
            chk("wr0_num", 32'(wr0_num), 32'(p0.num));
            chk("wr0_data", wr0_data, p0.data);
        end
        if (e1) begin
            chk("wr1_num", 32'(wr1_num), 32'(p1.num));
            chk("wr1_data", wr1_data, p1.data);
        end
        chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
        chk("pend_mask", pend_mask, mask);
        if (rst) chk("ll_ready", 32'(ll_ready), 32'(q.size() < DEPTH));
        m_pop  = k;
        m_push = rst && ll_valid && (q.size() < DEPTH) && (ll_num != 0);
    endtask

    task automatic adv();
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            repeat (m_pop) void'(q.pop_front());
            if (m_push) begin
                e.num = ll_num; e.data = ll_data;
                q.push_back(e);
            end
        end
        #1;
    endtask

    // Shorthands: both lanes busy on r10/r11 with an optional ll beat, or lanes idle.
    task automatic busy(input bit v, input logic [4:0] ln, input logic [31:0] ld);
        drive(1, 5'd10, 32'hB0, 1, 5'd11, 32'hB1, v, ln, ld);
    endtask
    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        // Reset held for two cycles, lanes requesting to show no write escapes.
        drive(1, 5'd2, 32'h5, 1, 5'd3, 32'h6, 1, 5'd4, 32'h7);
        chk("rst_wr0_en", 32'(wr0_en), 32'd0);
        adv();
        drive(1, 5'd2, 32'h5, 1, 5'd3, 32'h6, 0, 0, 0);
        chk("rst_wr1_en", 32'(wr1_en), 32'd0);
        adv();
        rst = 1'b1;
        idle();
        chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("post_rst_mask", pend_mask, 32'd0);
        chk("post_rst_ready", 32'(ll_ready), 32'd1);
        chk("post_rst_wr0", 32'(wr0_en), 32'd0);
        adv();

        // Lanes pass through; ll r5 queued and drained next idle cycle.
        drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 5'd5, 32'hAA);
        chk("pt_wr0_num", 32'(wr0_num), 32'd3);
        chk("pt_wr0_data", wr0_data, 32'h11);
        chk("pt_wr1_num", 32'(wr1_num), 32'd4);
        chk("pt_wr1_data", wr1_data, 32'h22);
        adv();
        idle();
        chk("pend_r5", pend_mask, 32'h20);
        chk("drain_wr0_num", 32'(wr0_num), 32'd5);
        chk("drain_wr0_data", wr0_data, 32'hAA);
        chk("drain_wr1_en", 32'(wr1_en), 32'd0);
        adv();

        // Two entries drained together on an idle cycle.
        busy(1, 5'd6, 32'h1); adv();
        busy(1, 5'd7, 32'h2); adv();
        idle();
        chk("dual_cnt", 32'(fifo_cnt), 32'd2);
        chk("dual_wr0", {wr0_num, wr0_data[26:0]}, {5'd6, 27'h1});
        chk("dual_wr1", {wr1_num, wr1_data[26:0]}, {5'd7, 27'h2});
        adv();
        idle();
        chk("dual_cnt_after", 32'(fifo_cnt), 32'd0);
        adv();

        // Fill to DEPTH, stall the fifth beat, free a slot under lane0-only, then accept.
        for (int i = 0; i < DEPTH; i++) begin
            busy(1, 5'(12 + i), 32'(32'h100 + i)); adv();
        end
        busy(1, 5'd16, 32'h104);
        chk("full_ready", 32'(ll_ready), 32'd0);
        chk("full_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_mask", pend_mask, 32'h0000_F000);
        adv();
        drive(1, 5'd1, 32'hC1, 0, 0, 0, 1, 5'd16, 32'h104);
        chk("full_pop_ready", 32'(ll_ready), 32'd0);
        chk("free_wr1_num", 32'(wr1_num), 32'd12);
        adv();
        busy(1, 5'd16, 32'h104);
        chk("fifth_ready", 32'(ll_ready), 32'd1);
        adv();
        idle();
        chk("order_a", {24'(wr0_num), 3'(wr1_num), wr0_data[4:0]}, {24'd13, 3'(5'd14), 5'h01});
        adv();
        idle();
        chk("order_b0", 32'(wr0_num), 32'd15);
        chk("order_b1", wr1_data, 32'h104);
        adv();

        // Only lane0 -> head on port1; only lane1 -> head on port0.
        busy(1, 5'd9, 32'h99); adv();
        drive(1, 5'd1, 32'hD1, 0, 0, 0, 0, 0, 0);
        chk("l0only_wr0", 32'(wr0_num), 32'd1);
        chk("l0only_wr1", {wr1_num, wr1_data[26:0]}, {5'd9, 27'h99});
        adv();
        busy(1, 5'd8, 32'h88); adv();
        drive(0, 0, 0, 1, 5'd2, 32'hD2, 0, 0, 0);
        chk("l1only_wr0", {wr0_num, wr0_data[26:0]}, {5'd8, 27'h88});
        chk("l1only_wr1", 32'(wr1_num), 32'd2);
        adv();

        // Same destination twice: both issued, younger on port1.
        busy(1, 5'd20, 32'hE0); adv();
        busy(1, 5'd20, 32'hE1); adv();
        idle();
        chk("waw_mask", pend_mask, 32'h0010_0000);
        chk("waw_wr0", wr0_data, 32'hE0);
        chk("waw_wr1", wr1_data, 32'hE1);
        adv();

        // r0 filtering on both the ll stream and lane0.
        drive(1, 5'd0, 32'hF0, 0, 0, 0, 1, 5'd0, 32'hF1);
        chk("r0_ll_ready", 32'(ll_ready), 32'd1);
        chk("r0_lane_wr0", 32'(wr0_en), 32'd0);
        adv();
        idle();
        chk("r0_cnt", 32'(fifo_cnt), 32'd0);
        adv();

        // Reset mid-operation discards queued results.
        busy(1, 5'd21, 32'h21); adv();
        busy(1, 5'd22, 32'h22); adv();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 5'd23, 32'h23);
        chk("midrst_wr0", 32'(wr0_en), 32'd0);
        adv();
        rst = 1'b1;
        idle();
        chk("midrst_cnt", 32'(fifo_cnt), 32'd0);
        chk("midrst_mask", pend_mask, 32'd0);
        adv();

        // Short pseudo-random soak under the model.
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1), 5'($urandom), $urandom,
                  $urandom_range(0, 1), 5'($urandom), $urandom,
                  $urandom_range(0, 1), 5'($urandom), $urandom);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
